ucaspian_axon: RTL and testbench
================================

# ucaspian_axon

Axon stage of the uCaspian core: accepts fire events from the neuron stage on the neuron -> axon handshake, looks up each firing axon's outgoing synapse range in a configuration RAM, and streams every synapse index in that range to the synapse stage, one per cycle under valid/ready flow control. It is the receiving end of the neuron's axon output and sits between the neuron and the synapse/dendrite path.

## Interface
- No parameters. Widths are fixed: 256 axons, 4096 synapses.
- clk  in  1  core clock; the only clock.
- reset  in  1  synchronous, active-high.
- clear_act  in  1  abort any in-flight traversal; level, held until clear_done.
- clear_config  in  1  zero the whole axon config RAM; also aborts any traversal; level, held until clear_done.
- clear_done  out  1  clear finished; held high until the clear input drops.
- config_addr  in  8  axon being configured.
- config_value  in  12  config payload.
- config_byte  in  3  config sub-word select.
- config_enable  in  1  config write strobe.
- step_done  out  1  registered; high when idle with nothing pending.
- axon_addr  in  8  firing neuron/axon index.
- axon_vld  in  1  fire valid.
- axon_rdy  out  1  combinational; fire accepted on vld && rdy.
- synapse_addr  out  12  synapse index to process.
- synapse_vld  out  1  synapse index valid.
- synapse_rdy  in  1  downstream accepts on vld && rdy.

## Operation
- Storage: two dp_ram_16x256 instances, both addressed by axon index.
  - start RAM: bits [11:0] hold the first synapse index.
  - count RAM: bits [7:0] hold the synapse count, 0..255.
  - Both RAMs share one read address and one read enable.
- Config writes:
  - config_byte 1 latches config_value[11:0] into start_hold.
  - config_byte 2 writes start_hold to the start RAM and config_value[7:0] to the count RAM at config_addr.
  - The RAM write is registered and lands one cycle after the strobe.
  - All other config_byte values are ignored.
  - config_enable has priority over clears and fire acceptance.
- FSM states: IDLE, READ, ISSUE, CLEAR.
  - IDLE: axon_rdy = 1 unless config_enable, clear_act or clear_config is high. On handshake, register axon_addr, pulse RAM read enable, go to READ.
  - READ: RAM data is valid this cycle. Load ptr <= start and remain <= count. If count == 0, go to IDLE. Otherwise go to ISSUE with synapse_vld <= 1 and synapse_addr <= start.
  - ISSUE: on synapse_rdy, ptr increments and remain decrements. ptr is 12-bit and wraps 4095 -> 0. If remain == 1, drop synapse_vld and go to IDLE. Otherwise present ptr+1 next cycle. synapse_addr and synapse_vld hold while synapse_rdy is low.
  - CLEAR: entered from any state when clear_act or clear_config is high. synapse_vld <= 0 immediately; any partial traversal is discarded. A counter runs 0..255. Under clear_config only, both RAMs are written with 0 at the counter address. After the write to address 255, clear_done <= 1 and the counter holds. When the clear input drops, clear_done <= 0, the counter returns to 0, and the FSM goes to IDLE.
- axon_rdy is low in READ, ISSUE and CLEAR. Upstream holds axon_addr and axon_vld stable until accepted.
- step_done <= (state == IDLE) && ~axon_vld && ~synapse_vld && ~config_enable.

## Timing
- Reset values: synapse_vld 0, synapse_addr 0, clear_done 0, step_done 0, FSM IDLE, counter 0. axon_rdy is 0 while reset is high. RAM contents are not reset.
- Latency: fire handshake in cycle T produces the first synapse_vld in T+2.
- Throughput: N synapses take N cycles with synapse_rdy held high. The next fire is accepted in the cycle after the last synapse handshake, so a fire costs N+2 cycles.
- A count == 0 fire occupies 2 cycles: accept, then READ, then IDLE with no synapse_vld.
- A config write must land at least one cycle before a fire to the same axon is accepted. The block does not forward written data.
- Reset mid-traversal: next cycle, synapse_vld = 0 and the FSM is IDLE.
- Clear timing: with clear_config asserted in cycle C, clear_done rises in C+257.

## Test plan
- Config axon 5: start = 100, count = 3. Fire 5 with synapse_rdy = 1 -> synapse_addr 100, 101, 102 in consecutive cycles starting T+2; axon_rdy returns at T+5.
- Config axon 7: start = 4094, count = 4. Fire 7 -> synapse_addr 4094, 4095, 0, 1 (wrap).
- Axon 9 with count = 0, then fire 9 immediately followed by fire 5 -> no synapse_vld for 9; axon 5's range (100, 101, 102) follows with no gap beyond READ.
- Fire 5 with synapse_rdy toggled 1,0,0,1,1 -> addresses 100, 101, 102 each accepted exactly once; no duplicates; synapse_addr stable while stalled.
- Assert clear_act during the second synapse of axon 5 -> synapse_vld drops the next cycle. A subsequent fire 5 restarts at 100.
- clear_config for 260 cycles -> clear_done high at C+257. Fire 5 afterwards -> count 0, no synapse output. step_done = 1 once idle.

Source files
------------

// File: rtl/ucaspian_axon.sv
// Axon stage: turns each accepted fire event into a stream of synapse indices
// read from a per-axon (start, count) entry in the axon configuration RAM.

module dp_ram_16x256 (
   input  logic        clk,
   input  logic        wr_en,
   input  logic [7:0]  wr_addr,
   input  logic [15:0] wr_data,
   input  logic        rd_en,
   input  logic [7:0]  rd_addr,
   output logic [15:0] rd_data
);

   logic [15:0] mem [0:255];

   // Registered read: data for an address presented in cycle T is valid in T+1.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

module ucaspian_axon (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_act,
   input  logic        clear_config,
   output logic        clear_done,
   input  logic [7:0]  config_addr,
   input  logic [11:0] config_value,
   input  logic [2:0]  config_byte,
   input  logic        config_enable,
   output logic        step_done,
   input  logic [7:0]  axon_addr,
   input  logic        axon_vld,
   output logic        axon_rdy,
   output logic [11:0] synapse_addr,
   output logic        synapse_vld,
   input  logic        synapse_rdy
);

   // Handshakes: a transfer happens in any cycle where vld && rdy are both high;
   // the producer holds data and vld stable until that cycle.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_ISSUE = 2'd2,
      S_CLEAR = 2'd3
   } state_t;

   state_t      state;
   logic [11:0] start_hold;
   logic        cfg_wr_pend;
   logic [7:0]  cfg_wr_addr;
   logic [11:0] cfg_wr_start;
   logic [7:0]  cfg_wr_count;
   logic [7:0]  clr_cnt;
   logic [11:0] ptr;
   logic [7:0]  remain;

   logic        clear_req;
   logic        fire;
   logic        clr_wr;
   logic        ram_wr_en;
   logic [7:0]  ram_wr_addr;
   logic [15:0] start_wr_data;
   logic [15:0] count_wr_data;
   logic [15:0] start_q;
   logic [15:0] count_q;
   logic [11:0] rd_start;
   logic [7:0]  rd_count;
   logic        unused_rd_bits;

   assign clear_req = clear_act | clear_config;
   assign axon_rdy  = ~reset & (state == S_IDLE) & ~config_enable & ~clear_req;
   assign fire      = axon_vld & axon_rdy;

   // A pending config write owns the shared write port; clear zeroing yields to it.
   assign clr_wr        = (state == S_CLEAR) & clear_config & ~clear_done;
   assign ram_wr_en     = cfg_wr_pend | clr_wr;
   assign ram_wr_addr   = cfg_wr_pend ? cfg_wr_addr : clr_cnt;
   assign start_wr_data = cfg_wr_pend ? {4'd0, cfg_wr_start} : 16'd0;
   assign count_wr_data = cfg_wr_pend ? {8'd0, cfg_wr_count} : 16'd0;

   assign rd_start       = start_q[11:0];
   assign rd_count       = count_q[7:0];
   assign unused_rd_bits = ^{start_q[15:12], count_q[15:8]};

   dp_ram_16x256 u_start_ram (
      .clk     (clk),
      .wr_en   (ram_wr_en),
      .wr_addr (ram_wr_addr),
      .wr_data (start_wr_data),
      .rd_en   (fire),
      .rd_addr (axon_addr),
      .rd_data (start_q)
   );

   dp_ram_16x256 u_count_ram (
      .clk     (clk),
      .wr_en   (ram_wr_en),
      .wr_addr (ram_wr_addr),
      .wr_data (count_wr_data),
      .rd_en   (fire),
      .rd_addr (axon_addr),
      .rd_data (count_q)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         start_hold   <= 12'd0;
         cfg_wr_pend  <= 1'b0;
         cfg_wr_addr  <= 8'd0;
         cfg_wr_start <= 12'd0;
         cfg_wr_count <= 8'd0;
      end else begin
         cfg_wr_pend <= config_enable & (config_byte == 3'd2);
         if (config_enable && config_byte == 3'd1)
            start_hold <= config_value;
         if (config_enable && config_byte == 3'd2) begin
            cfg_wr_addr  <= config_addr;
            cfg_wr_start <= start_hold;
            cfg_wr_count <= config_value[7:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         synapse_vld  <= 1'b0;
         synapse_addr <= 12'd0;
         clear_done   <= 1'b0;
         step_done    <= 1'b0;
         clr_cnt      <= 8'd0;
         ptr          <= 12'd0;
         remain       <= 8'd0;
      end else begin
         step_done <= (state == S_IDLE) & ~axon_vld & ~synapse_vld & ~config_enable;

         // Clears abort whatever is in flight; config strobes take precedence.
         if (clear_req && !config_enable && state != S_CLEAR) begin
            state       <= S_CLEAR;
            synapse_vld <= 1'b0;
            clr_cnt     <= 8'd0;
            clear_done  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (fire) state <= S_READ;
               end
               S_READ: begin
                  ptr    <= rd_start;
                  remain <= rd_count;
                  if (rd_count == 8'd0) begin
                     state <= S_IDLE;
                  end else begin
                     state        <= S_ISSUE;
                     synapse_vld  <= 1'b1;
                     synapse_addr <= rd_start;
                  end
               end
               S_ISSUE: begin
                  if (synapse_rdy) begin
                     ptr    <= ptr + 12'd1;
                     remain <= remain - 8'd1;
                     if (remain == 8'd1) begin
                        synapse_vld <= 1'b0;
                        state       <= S_IDLE;
                     end else begin
                        synapse_addr <= ptr + 12'd1;
                     end
                  end
               end
               S_CLEAR: begin
                  if (!clear_req) begin
                     clear_done <= 1'b0;
                     clr_cnt    <= 8'd0;
                     state      <= S_IDLE;
                  end else if (!clear_done) begin
                     if (clr_cnt == 8'd255) clear_done <= 1'b1;
                     else clr_cnt <= clr_cnt + 8'd1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ucaspian_axon.sv
// Directed bench for ucaspian_axon: config, fire traversal, stalls, clears, reset.

module tb_ucaspian_axon;

   logic        clk;
   logic        reset;
   logic        clear_act;
   logic        clear_config;
   logic        clear_done;
   logic [7:0]  config_addr;
   logic [11:0] config_value;
   logic [2:0]  config_byte;
   logic        config_enable;
   logic        step_done;
   logic [7:0]  axon_addr;
   logic        axon_vld;
   logic        axon_rdy;
   logic [11:0] synapse_addr;
   logic        synapse_vld;
   logic        synapse_rdy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [11:0] exp_q[$];

   ucaspian_axon dut (
      .clk           (clk),
      .reset         (reset),
      .clear_act     (clear_act),
      .clear_config  (clear_config),
      .clear_done    (clear_done),
      .config_addr   (config_addr),
      .config_value  (config_value),
      .config_byte   (config_byte),
      .config_enable (config_enable),
      .step_done     (step_done),
      .axon_addr     (axon_addr),
      .axon_vld      (axon_vld),
      .axon_rdy      (axon_rdy),
      .synapse_addr  (synapse_addr),
      .synapse_vld   (synapse_vld),
      .synapse_rdy   (synapse_rdy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard: every synapse handshake must match the next expected index.
   always @(negedge clk) begin
      if (!reset && synapse_vld && synapse_rdy) begin
         if (exp_q.size() > 0) begin
            logic [11:0] e;
            e = exp_q.pop_front();
            check("syn_addr", 32'(synapse_addr), 32'(e));
         end else begin
            check("syn_unexpected", 32'(synapse_vld & synapse_rdy), 32'd0);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_axon(input logic [7:0] a, input logic [11:0] st, input logic [7:0] cnt);
      config_enable = 1'b1;
      config_byte   = 3'd1;
      config_value  = st;
      tick;
      config_byte   = 3'd3;
      config_value  = 12'd999;
      tick;
      config_byte   = 3'd2;
      config_value  = {4'd0, cnt};
      config_addr   = a;
      tick;
      config_enable = 1'b0;
      config_byte   = 3'd0;
      tick;
   endtask

   task automatic fire(input logic [7:0] a, output int t_acc);
      axon_addr = a;
      axon_vld  = 1'b1;
      for (int i = 0; i < 600 && !axon_rdy; i++) tick;
      check("fire_rdy", 32'(axon_rdy), 32'd1);
      t_acc = cyc;
      tick;
      axon_vld = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 100 && (exp_q.size() != 0 || synapse_vld); i++) tick;
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int t;
      int t9;
      int t5;
      int c;
      int t_done;

      reset = 1'b1;
      clear_act = 1'b0;
      clear_config = 1'b0;
      config_addr = 8'd0;
      config_value = 12'd0;
      config_byte = 3'd0;
      config_enable = 1'b0;
      axon_addr = 8'd0;
      axon_vld = 1'b1;
      synapse_rdy = 1'b1;
      tick; tick; tick;
      check("rst_axon_rdy", 32'(axon_rdy), 32'd0);
      check("rst_syn_vld", 32'(synapse_vld), 32'd0);
      check("rst_syn_addr", 32'(synapse_addr), 32'd0);
      check("rst_clear_done", 32'(clear_done), 32'd0);
      check("rst_step_done", 32'(step_done), 32'd0);
      axon_vld = 1'b0;
      reset = 1'b0;
      tick; tick;
      check("idle_step_done", 32'(step_done), 32'd1);

      cfg_axon(8'd5, 12'd100, 8'd3);
      cfg_axon(8'd7, 12'd4094, 8'd4);
      cfg_axon(8'd9, 12'd50, 8'd0);

      // Basic traversal and latency
      exp_q.push_back(12'd100); exp_q.push_back(12'd101); exp_q.push_back(12'd102);
      fire(8'd5, t);
      check("t1_read_vld", 32'(synapse_vld), 32'd0);
      check("t1_read_rdy", 32'(axon_rdy), 32'd0);
      tick;
      check("t1_lat_vld", 32'(synapse_vld), 32'd1);
      check("t1_a0", 32'(synapse_addr), 32'd100);
      check("t1_busy_step", 32'(step_done), 32'd0);
      tick;
      check("t1_a1", 32'(synapse_addr), 32'd101);
      tick;
      check("t1_a2", 32'(synapse_addr), 32'd102);
      check("t1_rdy_low", 32'(axon_rdy), 32'd0);
      tick;
      check("t1_vld_end", 32'(synapse_vld), 32'd0);
      check("t1_rdy_back", 32'(axon_rdy), 32'd1);
      drain("t1_drain");

      // Pointer wrap
      exp_q.push_back(12'd4094); exp_q.push_back(12'd4095);
      exp_q.push_back(12'd0);    exp_q.push_back(12'd1);
      fire(8'd7, t);
      drain("t2_drain");

      // Zero-count axon followed immediately by axon 5
      exp_q.push_back(12'd100); exp_q.push_back(12'd101); exp_q.push_back(12'd102);
      fire(8'd9, t9);
      fire(8'd5, t5);
      check("t3_gap", 32'(t5 - t9), 32'd2);
      check("t3_read_vld", 32'(synapse_vld), 32'd0);
      tick;
      check("t3_first", 32'(synapse_addr), 32'd100);
      drain("t3_drain");

      // Backpressure pattern 1,0,0,1,1
      exp_q.push_back(12'd100); exp_q.push_back(12'd101); exp_q.push_back(12'd102);
      fire(8'd5, t);
      tick;
      check("t4_a0", 32'(synapse_addr), 32'd100);
      tick;
      check("t4_a1", 32'(synapse_addr), 32'd101);
      synapse_rdy = 1'b0;
      tick;
      check("t4_stall_addr", 32'(synapse_addr), 32'd101);
      check("t4_stall_vld", 32'(synapse_vld), 32'd1);
      tick;
      check("t4_stall2_addr", 32'(synapse_addr), 32'd101);
      synapse_rdy = 1'b1;
      tick;
      check("t4_a2", 32'(synapse_addr), 32'd102);
      tick;
      check("t4_vld_end", 32'(synapse_vld), 32'd0);
      drain("t4_drain");

      // clear_act mid-traversal
      exp_q.push_back(12'd100); exp_q.push_back(12'd101);
      fire(8'd5, t);
      tick;
      tick;
      check("t5_second", 32'(synapse_addr), 32'd101);
      clear_act = 1'b1;
      tick;
      check("t5_vld_drop", 32'(synapse_vld), 32'd0);
      for (int i = 0; i < 300 && !clear_done; i++) tick;
      check("t5_clear_done", 32'(clear_done), 32'd1);
      clear_act = 1'b0;
      tick;
      check("t5_clear_done_low", 32'(clear_done), 32'd0);
      check("t5_rdy_back", 32'(axon_rdy), 32'd1);
      exp_q.push_back(12'd100); exp_q.push_back(12'd101); exp_q.push_back(12'd102);
      fire(8'd5, t);
      drain("t5_restart");

      // Reset mid-traversal; RAM contents survive
      exp_q.push_back(12'd100);
      fire(8'd5, t);
      tick;
      tick;
      reset = 1'b1;
      tick;
      check("t6_rst_vld", 32'(synapse_vld), 32'd0);
      check("t6_rst_addr", 32'(synapse_addr), 32'd0);
      reset = 1'b0;
      tick;
      check("t6_rdy_back", 32'(axon_rdy), 32'd1);
      check("t6_q_empty", 32'(exp_q.size()), 32'd0);
      exp_q.push_back(12'd100); exp_q.push_back(12'd101); exp_q.push_back(12'd102);
      fire(8'd5, t);
      drain("t6_ram_kept");

      // clear_config timing and zeroed RAM
      c = cyc;
      clear_config = 1'b1;
      t_done = -1;
      for (int i = 0; i < 260; i++) begin
         tick;
         if (clear_done && t_done < 0) t_done = cyc;
      end
      check("t7_done_cycle", 32'(t_done), 32'(c + 257));
      check("t7_done_held", 32'(clear_done), 32'd1);
      clear_config = 1'b0;
      tick;
      check("t7_done_low", 32'(clear_done), 32'd0);
      fire(8'd5, t);
      tick;
      check("t7_no_vld", 32'(synapse_vld), 32'd0);
      tick;
      tick;
      check("t7_no_vld2", 32'(synapse_vld), 32'd0);
      check("t7_step_done", 32'(step_done), 32'd1);
      check("t7_q_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
